// File: rtl/player_feedback.sv
// Per-player feedback lamps/buzzer driven from a 4-deep command FIFO on a memory-mapped bus.
// Define FEEDBACK_BUZZER_EN to enable the buzzer square-wave; otherwise buzzer is tied low.
module player_feedback #(
  parameter logic [15:0] BASE_ADR        = 16'd240,
  parameter int          TICKS_PER_MS    = 50000,
  parameter int          GAP_MS          = 10,
  parameter int          BUZZ_HALF_TICKS = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [3:0]  led,
  output logic        buzzer,
  output logic        busy
);

  localparam logic [15:0] STATUS_ADR = BASE_ADR + 16'd1;
  localparam int          PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_fifo_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;

  logic [PW-1:0] r_presc;
  logic [15:0]   r_ms_left;
  logic [3:0]    r_mask;
  logic [3:0]    r_led;
  logic          r_busy;

  logic        w_sel_cmd;
  logic        w_flush;
  logic        w_push_req;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_status_rd;
  logic        w_ms_wrap;
  logic        w_last_ms;
  logic [15:0] w_head;
  logic [1:0]  w_state_bits;

  // Bus decode; the all-zero command is a flush and never occupies a FIFO slot.
  assign w_sel_cmd   = memwrite && (adr == BASE_ADR);
  assign w_flush     = w_sel_cmd && (writedata == 16'h0000);
  assign w_push_req  = w_sel_cmd && (writedata != 16'h0000);
  assign w_status_rd = memread && (adr == STATUS_ADR);
  assign w_full      = (r_count == 3'd4);
  assign w_pop       = (r_state == IDLE) && (r_count != 3'd0) && !w_flush;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;
  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_ms_wrap   = (r_presc == PRESC_LAST);
  assign w_last_ms   = (r_ms_left == 16'd1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (w_flush) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An overflowing push in the same cycle as a status read keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_status_rd) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_next = ON;
        end
      end
      ON: begin
        if (w_ms_wrap && w_last_ms) begin
          w_state_next = (GAP_MS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (w_ms_wrap && w_last_ms) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_flush) begin
      w_state_next = IDLE;
    end
  end

  // Millisecond prescaler and remaining-ms counter shared by ON and GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_ms_left <= 16'd0;
      r_mask    <= 4'd0;
    end else if (w_flush) begin
      r_presc   <= '0;
      r_ms_left <= 16'd0;
    end else if (w_pop) begin
      r_presc   <= '0;
      r_ms_left <= (w_head[10:0] == 11'd0) ? 16'd1 : {5'd0, w_head[10:0]};
      r_mask    <= w_head[15:12];
    end else if (r_state != IDLE) begin
      if (w_ms_wrap) begin
        r_presc <= '0;
        if (w_last_ms) begin
          r_ms_left <= (r_state == ON) ? 16'(GAP_MS) : 16'd0;
        end else begin
          r_ms_left <= r_ms_left - 16'd1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Visible outputs trail the control state by one edge, so led rises two edges after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led  <= 4'd0;
      r_busy <= 1'b0;
    end else if (w_flush) begin
      r_led  <= 4'd0;
      r_busy <= 1'b0;
    end else begin
      r_led  <= (r_state == ON) ? r_mask : 4'd0;
      r_busy <= (r_state != IDLE) || (r_count != 3'd0);
    end
  end

`ifdef FEEDBACK_BUZZER_EN
  localparam int BW = (BUZZ_HALF_TICKS > 1) ? $clog2(BUZZ_HALF_TICKS) : 1;
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_HALF_TICKS - 1);

  logic          r_buzz_en;
  logic          r_buzz_phase;
  logic [BW-1:0] r_buzz_cnt;
  logic          r_buzzer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buzz_en    <= 1'b0;
      r_buzz_phase <= 1'b0;
      r_buzz_cnt   <= '0;
      r_buzzer     <= 1'b0;
    end else if (w_flush) begin
      r_buzz_en    <= 1'b0;
      r_buzz_phase <= 1'b0;
      r_buzz_cnt   <= '0;
      r_buzzer     <= 1'b0;
    end else begin
      r_buzzer <= (r_state == ON) && r_buzz_en && r_buzz_phase;
      if (w_pop) begin
        r_buzz_en    <= w_head[11];
        r_buzz_phase <= 1'b1;
        r_buzz_cnt   <= '0;
      end else if (r_state == ON) begin
        if (r_buzz_cnt == BUZZ_LAST) begin
          r_buzz_cnt   <= '0;
          r_buzz_phase <= ~r_buzz_phase;
        end else begin
          r_buzz_cnt <= r_buzz_cnt + 1'b1;
        end
      end
    end
  end

  assign buzzer = r_buzzer;
`else
  localparam int W_UNUSED_HALF = BUZZ_HALF_TICKS;
  logic w_unused_buzz_bit;
  assign w_unused_buzz_bit = w_head[11];
  assign buzzer = 1'b0;
`endif

  assign led          = r_led;
  assign busy         = r_busy;
  assign w_state_bits = r_state;
  assign readdata     = w_status_rd
                      ? {r_busy, r_ovf, r_count, w_state_bits, 5'd0, r_led}
                      : 16'h0000;

endmodule

// File: tb/tb_player_feedback.sv
// Self-checking bench for player_feedback: table-driven commands with a per-cycle scoreboard,
// plus hand-written overflow, flush, ignore and reset sequences.
module tb_player_feedback;

  localparam logic [15:0] BASE = 16'd240;
  localparam logic [15:0] STAT = 16'd241;

  logic        clk;
  logic        rst;
  logic        memwrite;
  logic        memread;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [3:0]  led;
  logic        buzzer;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  mask;
    int          on_cycles;
  } vec_t;

  typedef struct {
    logic [3:0] led;
    logic       bz;
    logic       busy;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  player_feedback #(
    .BASE_ADR(16'd240),
    .TICKS_PER_MS(4),
    .GAP_MS(1),
    .BUZZ_HALF_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memwrite(memwrite),
    .memread(memread),
    .adr(adr),
    .writedata(writedata),
    .readdata(readdata),
    .led(led),
    .buzzer(buzzer),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Drives one write across one clock edge, returns at the following negedge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
    adr       = 16'd0;
    writedata = 16'd0;
  endtask

  task automatic run_cmd(input vec_t v);
    exp_t e;
    logic bz_en;
    int   k_idx;
`ifdef FEEDBACK_BUZZER_EN
    bz_en = v.cmd[11];
`else
    bz_en = 1'b0;
`endif
    for (int k = 1; k <= v.on_cycles + 6; k++) begin
      e.led  = (k >= 2 && k <= v.on_cycles + 1) ? v.mask : 4'd0;
      e.bz   = 1'b0;
      if (bz_en && k >= 2 && k <= v.on_cycles + 1) begin
        e.bz = (((k - 2) / 2) % 2) == 0;
      end
      e.busy = (k <= v.on_cycles + 5);
      sb_q.push_back(e);
    end
    wr(BASE, v.cmd);
    k_idx = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      if (led !== e.led || buzzer !== e.bz || busy !== e.busy) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd %h cycle %0d: got led=%b bz=%b busy=%b expected led=%b bz=%b busy=%b",
                 v.cmd, k_idx, led, buzzer, busy, e.led, e.bz, e.busy);
      end else begin
        n_checks++;
      end
      k_idx++;
    end
    $display("cmd %h applied: %0d cycles checked", v.cmd, v.on_cycles + 6);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int act_cnt;

    vecs[0] = '{cmd: 16'h3002, mask: 4'b0011, on_cycles: 8};
    vecs[1] = '{cmd: 16'h4000, mask: 4'b0100, on_cycles: 4};
    vecs[2] = '{cmd: 16'h8801, mask: 4'b1000, on_cycles: 4};
    vecs[3] = '{cmd: 16'hF003, mask: 4'b1111, on_cycles: 12};
    vecs[4] = '{cmd: 16'h1001, mask: 4'b0001, on_cycles: 4};
    vecs[5] = '{cmd: 16'h2801, mask: 4'b0010, on_cycles: 4};

    rst       = 1'b1;
    memwrite  = 1'b0;
    memread   = 1'b1;
    adr       = STAT;
    writedata = 16'd0;
    repeat (2) @(negedge clk);
    check("reset led", {28'd0, led}, 32'd0);
    check("reset buzzer", {31'd0, buzzer}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset readdata", {16'd0, readdata}, 32'd0);
    rst     = 1'b0;
    memread = 1'b0;
    adr     = 16'd0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i]);
    end

    // Writes to the status address and to unrelated addresses must not queue anything.
    wr(STAT, 16'h3002);
    wr(16'h0100, 16'h3002);
    repeat (3) @(negedge clk);
    check("ignore busy", {31'd0, busy}, 32'd0);
    check("ignore led", {28'd0, led}, 32'd0);
    memread = 1'b1;
    adr     = STAT;
    #1;
    check("ignore count", {29'd0, readdata[13:11]}, 32'd0);
    memread = 1'b0;
    adr     = 16'd0;
    #1;
    check("readdata idle", {16'd0, readdata}, 32'd0);

    // Overflow: 6 back-to-back writes -> 1 popped, 4 queued, 1 dropped.
    @(negedge clk);
    memwrite  = 1'b1;
    adr       = BASE;
    writedata = 16'h1001;
    repeat (6) @(negedge clk);
    memwrite  = 1'b0;
    memread   = 1'b1;
    adr       = STAT;
    #1;
    check("ovf flag set", {31'd0, readdata[14]}, 32'd1);
    check("ovf count 4", {29'd0, readdata[13:11]}, 32'd4);
    check("ovf busy bit", {31'd0, readdata[15]}, 32'd1);
    @(negedge clk);
    #1;
    check("ovf flag cleared", {31'd0, readdata[14]}, 32'd0);
    check("ovf count still 4", {29'd0, readdata[13:11]}, 32'd4);
    memread = 1'b0;
    adr     = 16'd0;
    wait_idle("ovf drain");

    // Flush during ON with two entries queued.
    @(negedge clk);
    memwrite  = 1'b1;
    adr       = BASE;
    writedata = 16'h3002;
    @(negedge clk);
    writedata = 16'h1001;
    @(negedge clk);
    writedata = 16'h1001;
    @(negedge clk);
    memwrite  = 1'b0;
    memread   = 1'b1;
    adr       = STAT;
    #1;
    check("pre-flush count", {29'd0, readdata[13:11]}, 32'd2);
    check("pre-flush state", {30'd0, readdata[10:9]}, 32'd1);
    check("pre-flush led", {28'd0, readdata[3:0]}, 32'h3);
    @(negedge clk);
    memread   = 1'b0;
    memwrite  = 1'b1;
    adr       = BASE;
    writedata = 16'h0000;
    @(negedge clk);
    memwrite  = 1'b0;
    check("flush led", {28'd0, led}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    memread = 1'b1;
    adr     = STAT;
    #1;
    check("flush state", {30'd0, readdata[10:9]}, 32'd0);
    check("flush count", {29'd0, readdata[13:11]}, 32'd0);
    memread = 1'b0;
    adr     = 16'd0;
    act_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (led != 4'd0 || busy != 1'b0) act_cnt++;
    end
    check("flush no resume", act_cnt, 32'd0);

    // Reset asserted mid-ON with a queued entry.
    @(negedge clk);
    memwrite  = 1'b1;
    adr       = BASE;
    writedata = 16'h2005;
    @(negedge clk);
    writedata = 16'h1001;
    @(negedge clk);
    memwrite  = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset led", {28'd0, led}, 32'h2);
    memread = 1'b1;
    adr     = STAT;
    rst     = 1'b1;
    #1;
    check("midreset led", {28'd0, led}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset buzzer", {31'd0, buzzer}, 32'd0);
    check("midreset readdata", {16'd0, readdata}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    memread = 1'b0;
    adr     = 16'd0;
    act_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (led != 4'd0 || busy != 1'b0 || buzzer != 1'b0) act_cnt++;
    end
    check("post-reset no resume", act_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
